// File: rtl/canvas_pkg.sv
// Shared sizes, state encoding and cell coordinate type for the drawing canvas.
package canvas_pkg;

    localparam int unsigned CANVAS_DIM = 32;
    localparam int unsigned CROP_OFF   = 2;
    localparam int unsigned CROP_DIM   = 28;
    localparam int unsigned DUMP_BEATS = CROP_DIM * CROP_DIM;
    localparam int unsigned IDX_W      = 5;
    localparam int unsigned CROP_END   = CROP_OFF + CROP_DIM - 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DUMP  = 2'd2
    } state_e;

    typedef struct packed {
        logic [IDX_W-1:0] row;
        logic [IDX_W-1:0] col;
    } cell_t;

endpackage

// File: rtl/canvas_if.sv
// Bit-serial crop dump stream between the framebuffer and the DNN input buffer.
interface canvas_if;

    logic iDumpStart;
    logic oDumpValid;
    logic iDumpReady;
    logic oDumpBit;
    logic oDumpLast;

    modport master (
        output iDumpStart,
        output iDumpReady,
        input  oDumpValid,
        input  oDumpBit,
        input  oDumpLast
    );

    modport slave (
        input  iDumpStart,
        input  iDumpReady,
        output oDumpValid,
        output oDumpBit,
        output oDumpLast
    );

endinterface

// File: rtl/canvas_raster_cnt.sv
// Row/column walker over the centred crop window; exposes the following cell
// and whether the current cell is the final one.
module canvas_raster_cnt
    import canvas_pkg::*;
(
    input  logic  clk,
    input  logic  rst_n,
    input  logic  load,
    input  logic  adv,
    output cell_t nxt_c,
    output logic  last_c
);

    cell_t cur;

    // Column wraps back to the crop's first column and bumps the row.
    always_comb begin
        nxt_c = cur;
        if (cur.col == IDX_W'(CROP_END)) begin
            nxt_c.col = IDX_W'(CROP_OFF);
            nxt_c.row = cur.row + IDX_W'(1);
        end else begin
            nxt_c.col = cur.col + IDX_W'(1);
        end
        last_c = (cur.row == IDX_W'(CROP_END)) && (cur.col == IDX_W'(CROP_END));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur <= '0;
        end else if (load) begin
            cur <= '{row: IDX_W'(CROP_OFF), col: IDX_W'(CROP_OFF)};
        end else if (adv) begin
            cur <= nxt_c;
        end
    end

endmodule

// File: rtl/canvas_framebuffer.sv
// 32x32 one-bit paint canvas with a registered display read port, a row-per-cycle
// clear, and a valid/ready bit-serial dump of the centred 28x28 crop.
module canvas_framebuffer
    import canvas_pkg::*;
(
    input  logic             clkVga,
    input  logic             iRstN,
    input  logic             iPaintEn,
    input  logic [IDX_W-1:0] iPaintX,
    input  logic [IDX_W-1:0] iPaintY,
    input  logic             iClear,
    input  logic [IDX_W-1:0] iPixX,
    input  logic [IDX_W-1:0] iPixY,
    output logic             oPixBit,
    output logic             oBusy,
    canvas_if.slave          dump
);

    logic [CANVAS_DIM-1:0][CANVAS_DIM-1:0] mem;

    state_e           state, state_d;
    logic [IDX_W-1:0] clr_row, clr_row_d;
    logic             dump_valid, dump_valid_d;
    logic             dump_bit, dump_bit_d;
    logic             dump_last, dump_last_d;
    logic             cnt_load, cnt_adv;
    logic             paint_we, clr_we;
    cell_t            cnt_nxt;
    logic             cnt_last;

    canvas_raster_cnt u_raster (
        .clk    (clkVga),
        .rst_n  (iRstN),
        .load   (cnt_load),
        .adv    (cnt_adv),
        .nxt_c  (cnt_nxt),
        .last_c (cnt_last)
    );

    assign dump.oDumpValid = dump_valid;
    assign dump.oDumpBit   = dump_bit;
    assign dump.oDumpLast  = dump_last;

    // Next-state and dump beat staging; the beat register always holds the cell
    // the counter currently points at.
    always_comb begin
        state_d      = state;
        clr_row_d    = clr_row;
        dump_valid_d = dump_valid;
        dump_bit_d   = dump_bit;
        dump_last_d  = dump_last;
        cnt_load     = 1'b0;
        cnt_adv      = 1'b0;
        paint_we     = 1'b0;
        clr_we       = 1'b0;
        case (state)
            IDLE: begin
                paint_we = iPaintEn;
                if (iClear) begin
                    state_d   = CLEAR;
                    clr_row_d = '0;
                end else if (dump.iDumpStart) begin
                    state_d      = DUMP;
                    cnt_load     = 1'b1;
                    dump_valid_d = 1'b1;
                    dump_bit_d   = mem[IDX_W'(CROP_OFF)][IDX_W'(CROP_OFF)];
                    dump_last_d  = 1'b0;
                end
            end
            CLEAR: begin
                clr_we    = 1'b1;
                clr_row_d = clr_row + IDX_W'(1);
                if (clr_row == IDX_W'(CANVAS_DIM - 1)) begin
                    state_d = IDLE;
                end
            end
            DUMP: begin
                if (dump_valid && dump.iDumpReady) begin
                    if (cnt_last) begin
                        state_d      = IDLE;
                        dump_valid_d = 1'b0;
                        dump_bit_d   = 1'b0;
                        dump_last_d  = 1'b0;
                    end else begin
                        cnt_adv     = 1'b1;
                        dump_bit_d  = mem[cnt_nxt.row][cnt_nxt.col];
                        dump_last_d = (cnt_nxt.row == IDX_W'(CROP_END)) &&
                                      (cnt_nxt.col == IDX_W'(CROP_END));
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            state      <= IDLE;
            clr_row    <= '0;
            dump_valid <= 1'b0;
            dump_bit   <= 1'b0;
            dump_last  <= 1'b0;
            oBusy      <= 1'b0;
        end else begin
            state      <= state_d;
            clr_row    <= clr_row_d;
            dump_valid <= dump_valid_d;
            dump_bit   <= dump_bit_d;
            dump_last  <= dump_last_d;
            oBusy      <= (state_d != IDLE);
        end
    end

    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            mem <= '0;
        end else if (clr_we) begin
            mem[clr_row] <= '0;
        end else if (paint_we) begin
            mem[iPaintY][iPaintX] <= 1'b1;
        end
    end

    // Display read sees the pre-write value when painting the same cell.
    always_ff @(posedge clkVga or negedge iRstN) begin
        if (!iRstN) begin
            oPixBit <= 1'b0;
        end else begin
            oPixBit <= mem[iPixY][iPixX];
        end
    end

endmodule

// File: tb/tb_canvas_framebuffer.sv
// Directed bench for canvas_framebuffer: paint/read, clear, dump with and without
// backpressure, clear/dump collision and reset abort.
module tb_canvas_framebuffer;

    logic       clkVga = 1'b0;
    logic       iRstN;
    logic       iPaintEn;
    logic [4:0] iPaintX;
    logic [4:0] iPaintY;
    logic       iClear;
    logic [4:0] iPixX;
    logic [4:0] iPixY;
    logic       oPixBit;
    logic       oBusy;

    canvas_if dump_if ();

    canvas_framebuffer dut (
        .clkVga   (clkVga),
        .iRstN    (iRstN),
        .iPaintEn (iPaintEn),
        .iPaintX  (iPaintX),
        .iPaintY  (iPaintY),
        .iClear   (iClear),
        .iPixX    (iPixX),
        .iPixY    (iPixY),
        .oPixBit  (oPixBit),
        .oBusy    (oBusy),
        .dump     (dump_if)
    );

    always #5 clkVga = ~clkVga;

    int n_checks = 0;
    int n_fail   = 0;

    bit beat_bits [784];
    bit ref_bits  [784];
    int cap_beats, cap_cycles, cap_stall_err, cap_last_cnt, cap_last_idx;
    bit cap_done, cap_post_valid, cap_post_last;

    task automatic tick;
        @(posedge clkVga);
        #1;
    endtask

    task automatic paint_cell(input int x, input int y);
        iPaintEn = 1'b1;
        iPaintX  = 5'(x);
        iPaintY  = 5'(y);
        tick;
        iPaintEn = 1'b0;
    endtask

    // Collects beats of a running dump; records stall violations and framing.
    task automatic capture(input bit use_bp, input bit paint_during);
        bit prev_stall = 1'b0;
        bit prev_bit   = 1'b0;
        bit prev_last  = 1'b0;
        bit rdy, xfer, was_last;
        int hold = 0;
        cap_beats = 0; cap_cycles = 0; cap_stall_err = 0;
        cap_last_cnt = 0; cap_last_idx = -1;
        cap_done = 1'b0; cap_post_valid = 1'b1; cap_post_last = 1'b1;
        for (int k = 0; k < 784; k++) beat_bits[k] = 1'b0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if (prev_stall && (dump_if.oDumpBit !== prev_bit || dump_if.oDumpLast !== prev_last))
                cap_stall_err++;
            rdy = 1'b1;
            if (use_bp) begin
                if (cap_beats == 27 && hold < 5) begin
                    rdy = 1'b0;
                    hold++;
                end else begin
                    rdy = 1'($urandom_range(0, 1));
                end
            end
            dump_if.iDumpReady = rdy;
            if (paint_during) begin
                iPaintEn = 1'b1;
                iPaintX  = 5'($urandom_range(0, 31));
                iPaintY  = 5'($urandom_range(0, 31));
            end
            xfer     = dump_if.oDumpValid && rdy;
            was_last = dump_if.oDumpLast;
            if (xfer) begin
                if (cap_beats < 784) beat_bits[cap_beats] = dump_if.oDumpBit;
                if (was_last) begin
                    cap_last_cnt++;
                    cap_last_idx = cap_beats;
                end
                cap_beats++;
            end
            prev_stall = dump_if.oDumpValid && !rdy;
            prev_bit   = dump_if.oDumpBit;
            prev_last  = dump_if.oDumpLast;
            cap_cycles++;
            tick;
            if (xfer && was_last) begin
                cap_done       = 1'b1;
                cap_post_valid = dump_if.oDumpValid;
                cap_post_last  = dump_if.oDumpLast;
                break;
            end
            if (cap_beats > 800) break;
        end
        dump_if.iDumpReady = 1'b0;
        iPaintEn = 1'b0;
    endtask

    task automatic test_reset;
        n_checks++;
        if (oBusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b expected 0", oBusy); end
        n_checks++;
        if (dump_if.oDumpValid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b expected 0", dump_if.oDumpValid); end
        n_checks++;
        if (dump_if.oDumpLast !== 1'b0 || dump_if.oDumpBit !== 1'b0) begin
            n_fail++; $display("FAIL reset_bit_last: got bit=%0b last=%0b expected 0/0", dump_if.oDumpBit, dump_if.oDumpLast);
        end
        n_checks++;
        if (oPixBit !== 1'b0) begin n_fail++; $display("FAIL reset_pix: got %0b expected 0", oPixBit); end
    endtask

    task automatic test_paint_read;
        paint_cell(5, 7);
        iPixX = 5'd5; iPixY = 5'd7; tick;
        n_checks++;
        if (oPixBit !== 1'b1) begin n_fail++; $display("FAIL read_5_7: got %0b expected 1", oPixBit); end
        iPixX = 5'd6; tick;
        n_checks++;
        if (oPixBit !== 1'b0) begin n_fail++; $display("FAIL read_6_7: got %0b expected 0", oPixBit); end
        iPixX = 5'd9; iPixY = 5'd9;
        paint_cell(9, 9);
        n_checks++;
        if (oPixBit !== 1'b0) begin n_fail++; $display("FAIL same_cycle_old: got %0b expected 0", oPixBit); end
        tick;
        n_checks++;
        if (oPixBit !== 1'b1) begin n_fail++; $display("FAIL same_cycle_new: got %0b expected 1", oPixBit); end
    endtask

    task automatic test_clear;
        int busy_cnt = 0;
        int ones = 0;
        bit saw_valid = 1'b0;
        for (int i = 0; i < 10; i++) paint_cell(i * 3, i + 10);
        iPixX = 5'd0; iPixY = 5'd10; tick;
        n_checks++;
        if (oPixBit !== 1'b1) begin n_fail++; $display("FAIL clear_pre_read: got %0b expected 1", oPixBit); end
        iClear = 1'b1; tick; iClear = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (!oBusy) break;
            busy_cnt++;
            if (dump_if.oDumpValid) saw_valid = 1'b1;
            iPaintEn = 1'b1; iPaintX = 5'(cyc); iPaintY = 5'd0;
            dump_if.iDumpStart = (cyc == 5);
            tick;
        end
        iPaintEn = 1'b0; dump_if.iDumpStart = 1'b0;
        tick;
        if (dump_if.oDumpValid) saw_valid = 1'b1;
        n_checks++;
        if (busy_cnt != 32) begin n_fail++; $display("FAIL clear_busy_cycles: got %0d expected 32", busy_cnt); end
        n_checks++;
        if (saw_valid) begin n_fail++; $display("FAIL clear_dump_ignored: got valid=1 expected 0"); end
        for (int y = 0; y < 32; y++) begin
            for (int x = 0; x < 32; x++) begin
                iPixX = 5'(x); iPixY = 5'(y);
                tick;
                ones += int'(oPixBit);
            end
        end
        n_checks++;
        if (ones != 0) begin n_fail++; $display("FAIL clear_all_zero: got %0d set cells expected 0", ones); end
    endtask

    task automatic test_dump_ready;
        int ones = 0;
        paint_cell(2, 2);
        paint_cell(29, 2);
        paint_cell(29, 29);
        dump_if.iDumpStart = 1'b1; tick; dump_if.iDumpStart = 1'b0;
        n_checks++;
        if (dump_if.oDumpValid !== 1'b1 || dump_if.oDumpBit !== 1'b1 || oBusy !== 1'b1) begin
            n_fail++; $display("FAIL dump_first_beat: got valid=%0b bit=%0b busy=%0b expected 1/1/1",
                               dump_if.oDumpValid, dump_if.oDumpBit, oBusy);
        end
        capture(1'b0, 1'b0);
        for (int k = 0; k < 784; k++) ones += int'(beat_bits[k]);
        n_checks++;
        if (!cap_done || cap_beats != 784) begin n_fail++; $display("FAIL dump_beats: got %0d done=%0b expected 784", cap_beats, cap_done); end
        n_checks++;
        if (cap_cycles != 784) begin n_fail++; $display("FAIL dump_cycles: got %0d expected 784", cap_cycles); end
        n_checks++;
        if (beat_bits[0] !== 1'b1 || beat_bits[27] !== 1'b1 || beat_bits[783] !== 1'b1 || ones != 3) begin
            n_fail++; $display("FAIL dump_pattern: got b0=%0b b27=%0b b783=%0b ones=%0d expected 1/1/1/3",
                               beat_bits[0], beat_bits[27], beat_bits[783], ones);
        end
        n_checks++;
        if (cap_last_cnt != 1 || cap_last_idx != 783) begin
            n_fail++; $display("FAIL dump_last: got count=%0d idx=%0d expected 1/783", cap_last_cnt, cap_last_idx);
        end
        n_checks++;
        if (cap_post_valid !== 1'b0 || cap_post_last !== 1'b0 || oBusy !== 1'b0) begin
            n_fail++; $display("FAIL dump_end: got valid=%0b last=%0b busy=%0b expected 0/0/0",
                               cap_post_valid, cap_post_last, oBusy);
        end
        for (int k = 0; k < 784; k++) ref_bits[k] = beat_bits[k];
    endtask

    task automatic test_backpressure;
        int diffs = 0;
        dump_if.iDumpStart = 1'b1; tick; dump_if.iDumpStart = 1'b0;
        capture(1'b1, 1'b1);
        for (int k = 0; k < 784; k++) if (beat_bits[k] !== ref_bits[k]) diffs++;
        n_checks++;
        if (!cap_done || cap_beats != 784) begin n_fail++; $display("FAIL bp_beats: got %0d done=%0b expected 784", cap_beats, cap_done); end
        n_checks++;
        if (cap_stall_err != 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d changes expected 0", cap_stall_err); end
        n_checks++;
        if (diffs != 0) begin n_fail++; $display("FAIL bp_sequence: got %0d differing beats expected 0", diffs); end
        n_checks++;
        if (cap_last_cnt != 1 || cap_last_idx != 783 || cap_post_valid !== 1'b0) begin
            n_fail++; $display("FAIL bp_last: got count=%0d idx=%0d post_valid=%0b expected 1/783/0",
                               cap_last_cnt, cap_last_idx, cap_post_valid);
        end
    endtask

    task automatic test_collision;
        int busy_cnt = 0;
        bit saw_valid = 1'b0;
        iClear = 1'b1; dump_if.iDumpStart = 1'b1; dump_if.iDumpReady = 1'b1;
        tick;
        iClear = 1'b0; dump_if.iDumpStart = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (!oBusy) break;
            busy_cnt++;
            if (dump_if.oDumpValid) saw_valid = 1'b1;
            dump_if.iDumpStart = (cyc == 10);
            tick;
        end
        dump_if.iDumpStart = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (dump_if.oDumpValid || oBusy) saw_valid = 1'b1;
            tick;
        end
        dump_if.iDumpReady = 1'b0;
        n_checks++;
        if (busy_cnt != 32) begin n_fail++; $display("FAIL collision_busy: got %0d expected 32", busy_cnt); end
        n_checks++;
        if (saw_valid) begin n_fail++; $display("FAIL collision_no_dump: got activity after clear expected none"); end
    endtask

    task automatic test_reset_mid_dump;
        paint_cell(18, 5);
        paint_cell(2, 2);
        iPixX = 5'd18; iPixY = 5'd5;
        dump_if.iDumpReady = 1'b1;
        dump_if.iDumpStart = 1'b1; tick; dump_if.iDumpStart = 1'b0;
        repeat (100) tick;
        n_checks++;
        if (dump_if.oDumpBit !== 1'b1 || oPixBit !== 1'b1 || dump_if.oDumpValid !== 1'b1) begin
            n_fail++; $display("FAIL beat100_pre_reset: got bit=%0b pix=%0b valid=%0b expected 1/1/1",
                               dump_if.oDumpBit, oPixBit, dump_if.oDumpValid);
        end
        #2 iRstN = 1'b0;
        #1;
        n_checks++;
        if (dump_if.oDumpValid !== 1'b0 || dump_if.oDumpBit !== 1'b0 || dump_if.oDumpLast !== 1'b0 ||
            oBusy !== 1'b0 || oPixBit !== 1'b0) begin
            n_fail++; $display("FAIL reset_abort: got valid=%0b bit=%0b last=%0b busy=%0b pix=%0b expected all 0",
                               dump_if.oDumpValid, dump_if.oDumpBit, dump_if.oDumpLast, oBusy, oPixBit);
        end
        @(negedge clkVga);
        iRstN = 1'b1;
        tick;
        tick;
        n_checks++;
        if (oPixBit !== 1'b0) begin n_fail++; $display("FAIL post_reset_18_5: got %0b expected 0", oPixBit); end
        iPixX = 5'd2; iPixY = 5'd2;
        tick;
        n_checks++;
        if (oPixBit !== 1'b0) begin n_fail++; $display("FAIL post_reset_2_2: got %0b expected 0", oPixBit); end
        n_checks++;
        if (dump_if.oDumpValid !== 1'b0 || oBusy !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_idle: got valid=%0b busy=%0b expected 0/0", dump_if.oDumpValid, oBusy);
        end
        dump_if.iDumpReady = 1'b0;
    endtask

    initial begin
        iRstN = 1'b0;
        iPaintEn = 1'b0; iPaintX = '0; iPaintY = '0;
        iClear = 1'b0; iPixX = '0; iPixY = '0;
        dump_if.iDumpStart = 1'b0;
        dump_if.iDumpReady = 1'b0;
        #23 iRstN = 1'b1;
        tick;
        test_reset;
        test_paint_read;
        test_clear;
        test_dump_ready;
        test_backpressure;
        test_collision;
        test_reset_mid_dump;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
